fc8_clkrst_gen: RTL

Clock-enable and reset sequencer that sits directly upstream of `fc8_top`'s CPU, memory controller and VGA logic. It replaces the free-running `clk_div` divider with three things:
- a synchronised, stretched system reset;
- a phase-aligned 5 MHz CPU clock enable;
- a fractional (NCO) ~5.03 MHz pixel clock enable.

All are generated in the single `clk_20mhz` domain. It also provides a software reset request and a watchdog, and reports the cause of the last reset.

---
 rtl/fc8_clk_pkg.sv | 7 +
 rtl/fc8_rst_sync.sv | 12 +
 rtl/fc8_clkrst_gen.sv | 97 +++++++++
 3 files changed

// File: rtl/fc8_clk_pkg.sv
// fc8_clk_pkg: shared types and constants for the fc8 clock-enable / reset sequencer
package fc8_clk_pkg;
   typedef enum logic [1:0] {RC_POR = 2'b00, RC_SOFT = 2'b01, RC_WDT = 2'b10} rst_cause_t;
   typedef enum logic {ST_HOLD = 1'b0, ST_RUN = 1'b1} clkrst_state_t;
   localparam logic [15:0] PIX_INC_DEF = 16'd16482;
   localparam logic [1:0] CPU_CE_PHASE = 2'd3;
endpackage

// File: rtl/fc8_rst_sync.sv
// fc8_rst_sync: 2-flop reset synchroniser, asynchronous assert / synchronous deassert
module fc8_rst_sync (
   input  logic clk_i,
   input  logic rst_n_i,
   output logic rst_n_o
);
   logic [1:0] sync_q;
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) sync_q <= '0;
      else sync_q <= {sync_q[0], 1'b1};
   assign rst_n_o = sync_q[1];
endmodule

// File: rtl/fc8_clkrst_gen.sv
// fc8_clkrst_gen: stretched system reset, 5 MHz CPU enable and NCO pixel enable in the 20 MHz domain
module fc8_clkrst_gen
   import fc8_clk_pkg::*;
#(
   parameter int          RST_HOLD_CYCLES = 1024,
   parameter logic [15:0] PIX_INC         = PIX_INC_DEF,
   parameter int          WDT_TIMEOUT     = 1_000_000
) (
   input  logic       clk_20mhz,
   input  logic       rst_n,
   input  logic       soft_rst_req,
   input  logic       wdt_en,
   input  logic       wdt_kick,
   output logic       sys_rst_n,
   output logic       cpu_ce,
   output logic [1:0] cpu_phase,
   output logic       pix_ce,
   output logic [1:0] rst_cause
);
   localparam int HW = $clog2(RST_HOLD_CYCLES);
   localparam int WW = $clog2(WDT_TIMEOUT);
   clkrst_state_t state_q, state_d;
   rst_cause_t    cause_q, cause_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [WW-1:0] wdt_q, wdt_d;
   logic [1:0]    phase_q, phase_d;
   logic [15:0]   acc_q, acc_d, sum;
   logic          cpu_ce_q, cpu_ce_d, pix_ce_q, pix_ce_d, sys_rst_n_q, sys_rst_n_d;
   logic          carry, rst_s, expire;
   fc8_rst_sync u_sync (
      .clk_i   (clk_20mhz),
      .rst_n_i (rst_n),
      .rst_n_o (rst_s)
   );
   assign {carry, sum} = 17'(acc_q) + 17'(PIX_INC);
   // a kick in the expiry cycle cancels the timeout
   assign expire = wdt_en && !wdt_kick && (wdt_q == WW'(WDT_TIMEOUT - 1));
   always_comb begin
      state_d     = state_q;
      cause_d     = cause_q;
      hold_d      = hold_q;
      sys_rst_n_d = sys_rst_n_q;
      wdt_d       = '0;
      phase_d     = '0;
      cpu_ce_d    = 1'b0;
      acc_d       = '0;
      pix_ce_d    = 1'b0;
      if (state_q == ST_HOLD) begin
         if (rst_s) begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HW'(RST_HOLD_CYCLES - 1)) begin
               state_d     = ST_RUN;
               sys_rst_n_d = 1'b1;
               hold_d      = '0;
            end
         end
      end else if (soft_rst_req || expire) begin
         state_d     = ST_HOLD;
         sys_rst_n_d = 1'b0;
         hold_d      = '0;
         cause_d     = soft_rst_req ? RC_SOFT : RC_WDT;
      end else begin
         phase_d  = phase_q + 2'd1;
         cpu_ce_d = (phase_q + 2'd1) == CPU_CE_PHASE;
         acc_d    = sum;
         pix_ce_d = carry;
         wdt_d    = (wdt_en && !wdt_kick) ? wdt_q + 1'b1 : '0;
      end
   end
   always_ff @(posedge clk_20mhz or negedge rst_n)
      if (!rst_n) begin
         state_q     <= ST_HOLD;
         cause_q     <= RC_POR;
         hold_q      <= '0;
         wdt_q       <= '0;
         phase_q     <= '0;
         acc_q       <= '0;
         cpu_ce_q    <= 1'b0;
         pix_ce_q    <= 1'b0;
         sys_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         hold_q      <= hold_d;
         wdt_q       <= wdt_d;
         phase_q     <= phase_d;
         acc_q       <= acc_d;
         cpu_ce_q    <= cpu_ce_d;
         pix_ce_q    <= pix_ce_d;
         sys_rst_n_q <= sys_rst_n_d;
      end
   assign sys_rst_n = sys_rst_n_q;
   assign cpu_ce    = cpu_ce_q;
   assign cpu_phase = phase_q;
   assign pix_ce    = pix_ce_q;
   assign rst_cause = cause_q;
endmodule
